// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver feeding a one-byte valid/ready holding register.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_stream #(
    parameter int CLOCK_RATE = 42000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic       rx_overrun,
    output logic       rx_busy
);
    localparam int CPB   = CLOCK_RATE / BAUD_RATE;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             sync_p0;
    logic             sync_p1;  // rxs: the only view of the line the FSM ever uses

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            rx_overrun <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            // synchronizer stage boundary: pin -> sync_p0 -> sync_p1
            sync_p0    <= rx_pin;
            sync_p1    <= sync_p0;
            rx_err     <= 1'b0;
            rx_overrun <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!sync_p1) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!sync_p1) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CPB_LAST) begin
                        cnt   <= '0;
                        // LSB arrives first, so after eight shifts it sits in bit 0
                        shift <= {sync_p1, shift[7:1]};
                        if (idx == 3'd7)
                            state <= STOP;
                        else
                            idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CPB_LAST) begin
                        cnt <= '0;
                        if (sync_p1) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                            // a same-cycle accept frees the register for this byte
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            state  <= BREAK;
                            rx_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (sync_p1) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: directed frames plus randomized traffic, scored
// against a frame-level model (byte queue, error and overrun tallies).
`timescale 1ns/1ps
module tb_uart_rx_stream;
    localparam int CLOCK_RATE = 42000000;
    localparam int BAUD_RATE  = 115200;
    localparam int CPB        = CLOCK_RATE / BAUD_RATE;
    localparam int HALF       = CPB / 2;
    localparam int LAT_MIN    = HALF + 9 * CPB;
    localparam int LAT_MAX    = HALF + 9 * CPB + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_pin = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_overrun;
    logic       rx_busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    int         first_valid_cyc = -1;
    int         fall_cyc = 0;
    bit         done = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_stream #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_pin(rx_pin),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_err(rx_err),
        .rx_overrun(rx_overrun),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer side: record accepted bytes and pulses, and check hold stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_err) err_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_err || rx_overrun) check_val("err_ovr_excl", {31'd0, rx_err & rx_overrun}, 32'd0);
            if (rx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_rst && prev_valid && !prev_ready) begin
                check_val("hold_valid", {31'd0, rx_valid}, 32'd1);
                check_val("hold_data", {24'd0, rx_data}, {24'd0, prev_data});
            end
        end
        prev_rst   = rst_n;
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_data  = rx_data;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bits(input logic v, input int n);
        rx_pin = v;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
        drive_bits(stop, CPB);
    endtask

    task automatic check_bytes(input string tag);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check_val(tag, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        check_val({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check_val({tag, "_err"}, {31'd0, rx_err}, 32'd0);
        check_val({tag, "_ovr"}, {31'd0, rx_overrun}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        int         lat;
        int         lat_use;
        int         b_err;
        int         b_ovr;
        int         k;
        int         target;
        int         exp_err;
        int         gap;
        logic [7:0] b;
        logic       good;

        // reset state
        wait_cycles(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wait_cycles(10);

        // two back-to-back frames, consumer always ready, latency window
        rx_ready = 1'b1;
        b_err = err_cnt;
        first_valid_cyc = -1;
        send_frame(8'h55, 1'b1);
        lat = first_valid_cyc - fall_cyc;
        send_frame(8'hA5, 1'b1);
        wait_cycles(CPB);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA5);
        check_bytes("pair");
        check_val("pair_lat_window", {31'd0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 32'd1);
        check_val("pair_err", err_cnt - b_err, 32'd0);
        lat_use = (lat >= LAT_MIN && lat <= LAT_MAX) ? lat : LAT_MIN + 3;

        // short low glitch: busy briefly, no output, no error
        b_err = err_cnt;
        rx_pin = 1'b0;
        k = 0;
        while (!rx_busy && k < HALF + 3) begin
            wait_cycles(1);
            k++;
        end
        check_val("glitch_busy", {31'd0, rx_busy}, 32'd1);
        if (k < 100) wait_cycles(100 - k);
        rx_pin = 1'b1;
        k = 0;
        while (rx_busy && k < 2 * CPB) begin
            wait_cycles(1);
            k++;
        end
        check_val("glitch_idle", {31'd0, rx_busy}, 32'd0);
        check_val("glitch_err", err_cnt - b_err, 32'd0);
        check_bytes("glitch");

        // bad stop bit, long break, then a good frame
        b_err = err_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bits(1'b0, 2000);
        drive_bits(1'b1, 2 * CPB);
        send_frame(8'h81, 1'b1);
        wait_cycles(CPB);
        exp_q.push_back(8'h81);
        check_bytes("break");
        check_val("break_err", err_cnt - b_err, 32'd1);

        // consumer stalled: second byte overruns, first byte held
        rx_ready = 1'b0;
        b_ovr = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(20);
        check_val("stall_valid", {31'd0, rx_valid}, 32'd1);
        check_val("stall_data", {24'd0, rx_data}, 32'h11);
        check_val("stall_ovr", ovr_cnt - b_ovr, 32'd1);
        rx_ready = 1'b1;
        wait_cycles(1);
        check_val("stall_drop", {31'd0, rx_valid}, 32'd0);
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        check_bytes("stall");

        // accept the held byte on the exact cycle the next frame completes
        b_ovr = ovr_cnt;
        send_frame(8'h11, 1'b1);
        wait_cycles(5);
        target = cyc + lat_use - 1;
        fork
            send_frame(8'h22, 1'b1);
            begin
                k = 0;
                while (cyc != target && k < 20 * CPB) begin
                    wait_cycles(1);
                    k++;
                end
                rx_ready = 1'b1;
                wait_cycles(1);
                rx_ready = 1'b0;
                check_val("same_valid", {31'd0, rx_valid}, 32'd1);
                check_val("same_data", {24'd0, rx_data}, 32'h22);
            end
        join
        check_val("same_ovr", ovr_cnt - b_ovr, 32'd0);
        rx_ready = 1'b1;
        wait_cycles(1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        check_bytes("same");

        // reset during data bit 4 of 0xF0, then 0x0F
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_cycles(5 * CPB + HALF);
                rst_n = 1'b0;
                wait_cycles(3);
                check_idle_outputs("midrst");
                rst_n = 1'b1;
            end
        join
        send_frame(8'h0F, 1'b1);
        wait_cycles(CPB);
        exp_q.push_back(8'h0F);
        check_bytes("midrst");

        // randomized bytes, stop bits and consumer readiness
        b_err = err_cnt;
        b_ovr = ovr_cnt;
        exp_err = 0;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 6; n++) begin
                    b = 8'($urandom_range(0, 255));
                    good = ($urandom_range(0, 3) != 0);
                    send_frame(b, good);
                    if (good) begin
                        exp_q.push_back(b);
                    end else begin
                        exp_err++;
                        drive_bits(1'b1, 2 * CPB);
                    end
                    gap = $urandom_range(0, 40);
                    if (gap > 0) drive_bits(1'b1, gap);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    wait_cycles(1);
                    rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rx_ready = 1'b1;
        wait_cycles(CPB);
        check_bytes("rand");
        check_val("rand_err", err_cnt - b_err, exp_err);
        check_val("rand_ovr", ovr_cnt - b_ovr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Standalone UART receiver: 8N1 serial in, byte out.
- Converts the asynchronous RX pin into bytes on a valid/ready handshake with a one-byte holding register.
- Reports framing errors and overruns as single-cycle pulses.
- Sits between the RX pad and byte consumers: echo logic, command parsers, FIFOs.

Parameters:
- CLOCK_RATE, 42000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- Derived, not overridable:
  - CPB = CLOCK_RATE/BAUD_RATE, integer-truncated (364 at the defaults).
  - HALF = CPB/2 (182 at the defaults).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx_pin  input  1  raw serial line; idles high.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid&rx_ready at a clock edge.
- rx_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  one-cycle pulse: frame completed while holding register full.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - rx_data=0, rx_valid=0, rx_err=0, rx_overrun=0, rx_busy=0.
  - State=IDLE, counters=0.
  - Both synchronizer flops=1.
- Input path: 2-FF synchronizer on rx_pin. All decisions use the synchronized value rxs.
- Bit timer: cnt counts clock cycles within the current period. A period of length N ends when cnt==N-1; cnt then clears.
- States:
  - IDLE: rxs==0 -> START, cnt=0.
  - START, period HALF: at end, sample rxs.
    - 0 -> DATA, bit index=0.
    - 1 -> IDLE. Glitch: no output, no error.
  - DATA, period CPB per bit: at end of each period, shift rxs into bit[idx], LSB first. After idx 7 -> STOP.
  - STOP, period CPB: at end, sample rxs.
    - 1 -> frame good; deliver byte; go to IDLE.
    - 0 -> rx_err pulses on the next cycle; byte discarded; go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. A held-low line yields exactly one rx_err.
- Delivery, at the good-stop edge:
  - Holding register empty, or emptying in the same cycle (rx_valid&rx_ready): load rx_data; rx_valid=1 from the next cycle.
  - Holding register full and not accepted this cycle: byte dropped, rx_data unchanged, rx_overrun pulses one cycle.
- Handshake:
  - rx_valid stays high and rx_data stays stable until the cycle after rx_valid&rx_ready.
  - Accept and new load in the same cycle: rx_valid stays 1 with the new data.
- Latency: rx_valid rises no earlier than HALF+9*CPB and no later than HALF+9*CPB+4 cycles after the rx_pin falling edge.
- Back-to-back frames: the next start bit may follow the stop-bit sample immediately. IDLE detects it in the following cycle; no dead time beyond one cycle.
- rx_ready while rx_valid=0 has no effect.
- Reset mid-frame: immediate return to IDLE, partial byte lost, rx_valid cleared. After release, the receiver resynchronizes on the next falling edge. A low line at release is treated as a start bit.
- rx_err and rx_overrun never assert in the same cycle. Neither affects the holding register.

Test Plan:
- Default params; send 0x55, then 0xA5 at 115200, rx_ready=1 -> two rx_valid cycles with rx_data 0x55 then 0xA5; rx_valid first rises in cycle window [3458, 3462] after the falling edge; no rx_err.
- Low pulse of 100 clocks on an idle line -> rx_busy high ≤ HALF+3 cycles, then IDLE; no rx_valid, no rx_err.
- Frame 0x3C with stop bit forced 0, then line held low 2000 clocks, then high, then 0x81 -> exactly one rx_err pulse, no rx_valid for 0x3C; 0x81 delivered correctly.
- rx_ready=0; send 0x11, then 0x22 -> rx_valid=1 with rx_data=0x11 throughout; one rx_overrun pulse at the end of 0x22; raise rx_ready -> rx_valid drops the next cycle.
- rx_ready toggled to accept 0x11 on the exact cycle frame 0x22 completes -> no rx_overrun; rx_valid stays high with rx_data=0x22.
- Assert rst_n=0 during data bit 4 of 0xF0; release; send 0x0F -> no output for 0xF0; 0x0F delivered; all outputs 0 during reset.
